// File: rtl/pixel_delay_line_if.sv
// pixel_delay_line_if
//   Bundles the data-side signals of pixel_delay_line.
//   The master side (the pixel source or test driver) drives these:
//     clear       synchronous flush request
//     in_valid    a new sample is present; the line shifts this cycle
//     in_data     packed input pixel, with channel 0 in the LSBs
//   The slave side (the delay line itself) drives these:
//     out_data    oldest stage
//     out_valid   one-cycle strobe marking a new real sample on out_data
//     taps        all stages, with stage 0 (the newest) in the LSBs
//     fill_count  number of real samples held; saturates at DEPTH
//     primed      high when the line is full
//   The clock and reset are not part of the bundle; they stay plain module ports.
interface pixel_delay_line_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int DEPTH        = 4
);
    localparam int PW = DATA_WIDTH * NUM_CHANNELS;
    localparam int CW = $clog2(DEPTH + 1);

    logic                  clear;
    logic                  in_valid;
    logic [PW-1:0]         in_data;
    logic [PW-1:0]         out_data;
    logic                  out_valid;
    logic [DEPTH*PW-1:0]   taps;
    logic [CW-1:0]         fill_count;
    logic                  primed;

    modport master (
        output clear, in_valid, in_data,
        input  out_data, out_valid, taps, fill_count, primed
    );

    modport slave (
        input  clear, in_valid, in_data,
        output out_data, out_valid, taps, fill_count, primed
    );
endinterface

// File: rtl/pixel_delay_line.sv
// pixel_delay_line
//   A multi-channel register delay line. It delays each pixel by DEPTH accepted
//   samples and exposes every stage as a tap for the window and kernel logic.
//   The line advances only when in_valid is high. The delay is therefore counted
//   in samples, not in clock cycles.
//   Ports:
//     clk          rising-edge clock
//     async_reset  asynchronous, active-high reset; it clears all state
//     bus          pixel_delay_line_if.slave, which carries:
//                    clear, in_valid, in_data           (inputs)
//                    out_data, out_valid, taps,
//                    fill_count, primed                 (outputs)
//   Priority on each edge: async_reset > clear > shift > hold.
//   All outputs come straight from registers or from a compare on a register.
module pixel_delay_line #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int DEPTH        = 4
) (
    input  logic                clk,
    input  logic                async_reset,
    pixel_delay_line_if.slave   bus
);
    localparam int PW = DATA_WIDTH * NUM_CHANNELS;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] stage_reg [DEPTH];
    logic [CW-1:0] fill_count_reg;
    logic          out_valid_reg;
    logic          shift;

    // clear has priority over in_valid, so a sample offered during a flush is dropped.
    assign shift = bus.in_valid && !bus.clear;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else if (shift) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            stage_reg[0] <= bus.in_data;
        end
    end

    // On this shift the oldest stage receives a real sample exactly when at
    // least DEPTH-1 samples were already held.
    // The compare is done in int so that DEPTH=1 does not reduce to an
    // unsigned ">= 0" test.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            fill_count_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else if (bus.clear) begin
            fill_count_reg <= '0;
            out_valid_reg  <= 1'b0;
        end else if (shift) begin
            if (fill_count_reg != FULL) begin
                fill_count_reg <= fill_count_reg + CW'(1);
            end
            out_valid_reg <= (int'(fill_count_reg) + 1 >= DEPTH);
        end else begin
            out_valid_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign bus.taps[gi*PW +: PW] = stage_reg[gi];
        end
    endgenerate

    assign bus.out_data   = stage_reg[DEPTH-1];
    assign bus.out_valid  = out_valid_reg;
    assign bus.fill_count = fill_count_reg;
    assign bus.primed     = (fill_count_reg == FULL);
endmodule

// File: tb/tb_pixel_delay_line.sv
module tb_pixel_delay_line;
    logic clk = 1'b0;
    logic async_reset = 1'b1;
    always #5 clk = ~clk;

    pixel_delay_line_if #(.DATA_WIDTH(8), .NUM_CHANNELS(3), .DEPTH(4)) bus_a ();
    pixel_delay_line_if #(.DATA_WIDTH(12), .NUM_CHANNELS(1), .DEPTH(1)) bus_b ();

    pixel_delay_line #(.DATA_WIDTH(8), .NUM_CHANNELS(3), .DEPTH(4)) dut_a (
        .clk(clk), .async_reset(async_reset), .bus(bus_a)
    );
    pixel_delay_line #(.DATA_WIDTH(12), .NUM_CHANNELS(1), .DEPTH(1)) dut_b (
        .clk(clk), .async_reset(async_reset), .bus(bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard for dut_a. The queue holds the accepted samples that have
    // not yet been emitted on out_data.
    logic [23:0] sb_q [$];
    int          exp_cnt = 0;
    logic        exp_valid = 1'b0;
    logic [23:0] exp_out = '0;
    logic [95:0] snap;
    logic [95:0] exp_taps;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on dut_a, then update the model and check the outputs #1 after the edge.
    task automatic step(input string tag, input logic vld, input logic clr, input logic [23:0] d);
        bus_a.in_valid = vld;
        bus_a.clear    = clr;
        bus_a.in_data  = d;
        @(posedge clk);
        #1;
        if (clr) begin
            sb_q.delete();
            exp_cnt   = 0;
            exp_valid = 1'b0;
        end else if (vld) begin
            sb_q.push_back(d);
            if (exp_cnt < 4) exp_cnt++;
            if (sb_q.size() == 4) begin
                exp_valid = 1'b1;
                exp_out   = sb_q.pop_front();
            end else begin
                exp_valid = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
        end
        check({tag, ".out_valid"}, 128'(bus_a.out_valid), 128'(exp_valid));
        if (exp_valid) check({tag, ".out_data"}, 128'(bus_a.out_data), 128'(exp_out));
        check({tag, ".fill_count"}, 128'(bus_a.fill_count), 128'(exp_cnt));
        check({tag, ".primed"}, 128'(bus_a.primed), 128'(exp_cnt == 4));
        $display("step %s vld=%0b clr=%0b in=%06h -> out=%06h ov=%0b fill=%0d primed=%0b",
                 tag, vld, clr, d, bus_a.out_data, bus_a.out_valid, bus_a.fill_count, bus_a.primed);
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.clear = 1'b0; bus_a.in_data = '0;
        bus_b.in_valid = 1'b0; bus_b.clear = 1'b0; bus_b.in_data = '0;
        #12;
        async_reset = 1'b0;
        #1;
        check("rst.taps", 128'(bus_a.taps), 128'(0));
        check("rst.fill", 128'(bus_a.fill_count), 128'(0));
        check("rst.out_valid", 128'(bus_a.out_valid), 128'(0));
        check("rst.primed", 128'(bus_a.primed), 128'(0));

        // Test 1: reset mid-stream, asserted between clock edges.
        step("pre1", 1'b1, 1'b0, 24'hAAAAAA);
        step("pre2", 1'b1, 1'b0, 24'hBBBBBB);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 24'h555555;
        #1 async_reset = 1'b1;
        #1;
        check("arst.taps", 128'(bus_a.taps), 128'(0));
        check("arst.fill", 128'(bus_a.fill_count), 128'(0));
        check("arst.out_valid", 128'(bus_a.out_valid), 128'(0));
        check("arst.primed", 128'(bus_a.primed), 128'(0));
        bus_a.in_valid = 1'b0;
        #1 async_reset = 1'b0;
        sb_q.delete();
        exp_cnt = 0;
        $display("async reset pulse: taps=%0h fill=%0d", bus_a.taps, bus_a.fill_count);

        // Test 2: fill the line.
        step("fill0", 1'b1, 1'b0, 24'h010203);
        step("fill1", 1'b1, 1'b0, 24'h040506);
        step("fill2", 1'b1, 1'b0, 24'h070809);
        step("fill3", 1'b1, 1'b0, 24'h0A0B0C);
        check("fill.out_data", 128'(bus_a.out_data), 128'(24'h010203));
        check("fill.taps", 128'(bus_a.taps), 128'(96'h010203_040506_070809_0A0B0C));

        // Test 3: stall the line, then take one more sample.
        snap = bus_a.taps;
        for (int i = 0; i < 5; i++) begin
            step("stall", 1'b0, 1'b0, 24'hDEADBE);
            check("stall.taps", 128'(bus_a.taps), 128'(snap));
        end
        step("resume", 1'b1, 1'b0, 24'h111213);
        check("resume.out_data", 128'(bus_a.out_data), 128'(24'h040506));
        step("resume.idle", 1'b0, 1'b0, 24'h000000);

        // Test 4: clear takes priority over a shift in the same cycle.
        step("clear", 1'b1, 1'b1, 24'hFFFFFF);
        check("clear.taps", 128'(bus_a.taps), 128'(0));

        // Test 5: saturation and the tap ordering.
        for (int k = 1; k <= 20; k++) begin
            step("sat", 1'b1, 1'b0, 24'(k));
            exp_taps = '0;
            for (int s = 0; s < 4; s++) begin
                if (k - s >= 1) exp_taps[s*24 +: 24] = 24'(k - s);
            end
            check("sat.taps", 128'(bus_a.taps), 128'(exp_taps));
        end

        // Test 6: DEPTH=1 with a 12-bit, single-channel pixel.
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 12'hABC;
        @(posedge clk); #1;
        check("d1.out_data", 128'(bus_b.out_data), 128'(12'hABC));
        check("d1.out_valid", 128'(bus_b.out_valid), 128'(1));
        check("d1.fill", 128'(bus_b.fill_count), 128'(1));
        $display("d1 shift abc -> out=%03h ov=%0b", bus_b.out_data, bus_b.out_valid);
        bus_b.in_data = 12'h123;
        @(posedge clk); #1;
        check("d1.out_data2", 128'(bus_b.out_data), 128'(12'h123));
        check("d1.out_valid2", 128'(bus_b.out_valid), 128'(1));
        check("d1.primed", 128'(bus_b.primed), 128'(1));
        $display("d1 shift 123 -> out=%03h ov=%0b", bus_b.out_data, bus_b.out_valid);
        bus_b.in_valid = 1'b0;
        @(posedge clk); #1;
        check("d1.hold_valid", 128'(bus_b.out_valid), 128'(0));
        check("d1.hold_data", 128'(bus_b.out_data), 128'(12'h123));
        $display("d1 hold -> out=%03h ov=%0b", bus_b.out_data, bus_b.out_valid);
        bus_b.in_data = 12'hFFF;
        bus_b.in_valid = 1'b1;
        #1 async_reset = 1'b1;
        #1;
        check("d1.rst_data", 128'(bus_b.out_data), 128'(12'h000));
        check("d1.rst_fill", 128'(bus_b.fill_count), 128'(0));
        $display("d1 reset -> out=%03h fill=%0d", bus_b.out_data, bus_b.fill_count);
        bus_b.in_valid = 1'b0;
        #1 async_reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
